wb_trace_buffer: RTL and testbench
==================================

WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 SHALL have parameter: DEPTH, 8, number of buffered writeback events; power of two, 2..64.
REQ-002 SHALL have port: clk  input  1  single clock; all logic on posedge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: wb_pc  input  32  PC of the retiring instruction from the CPU debug writeback port.
REQ-005 SHALL have port: wb_rf_wen  input  1  register-file write enable from the CPU.
REQ-006 SHALL have port: wb_rf_addr  input  5  destination register number.
REQ-007 SHALL have port: wb_rf_wdata  input  32  writeback data.
REQ-008 SHALL have port: out_valid  output  1  head entry available to the trace checker.
REQ-009 SHALL have port: out_ready  input  1  trace checker accepts the head entry.
REQ-010 SHALL have port: out_pc / out_addr / out_wdata  output  32/5/32  head entry fields.
REQ-011 SHALL have port: count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-012 SHALL have port: overflow  output  1  sticky flag; at least one event was dropped.
REQ-013 SHALL have port: drop_cnt  output  16  dropped-event count; present only under WB_TRACE_DROP_CNT_EN.

Function
REQ-014 SHALL treat a cycle as an event only when wb_rf_wen=1 and wb_rf_addr!=0; writes to r0 and wen=0 cycles are ignored, never counted.
REQ-015 SHALL write {wb_pc, wb_rf_addr, wb_rf_wdata} at wr_ptr on the posedge of an accepted event; wr_ptr increments modulo DEPTH.
REQ-016 SHALL be first-word-fall-through: out_valid = (count!=0); out_* show the entry at rd_ptr combinationally from storage.
REQ-017 SHALL pop when out_valid && out_ready at posedge; rd_ptr increments modulo DEPTH; out_ready with out_valid=0 has no effect.
REQ-018 SHALL have latency exactly 1 cycle: event in cycle N into an empty buffer gives out_valid=1 in cycle N+1; no same-cycle bypass.
REQ-019 SHALL preserve event order strictly (FIFO); no reordering, no duplication.
REQ-020 SHALL, when full (count=DEPTH) with an event and a pop in the same cycle, accept the event; count stays DEPTH.
REQ-021 SHALL, when full with an event and no pop, drop the event, leave storage/pointers unchanged, and set overflow=1 from next cycle until reset.
REQ-022 SHALL, on simultaneous push and pop when not full and not empty, keep count unchanged.
REQ-023 SHALL keep count equal to (pushes - pops) since reset; never exceed DEPTH or underflow.
REQ-024 SHALL hold out_* stable while out_valid=1 and out_ready=0.

Reset
REQ-025 SHALL, on reset=1 at posedge, set wr_ptr=0, rd_ptr=0, count=0, overflow=0, drop_cnt=0, clear all storage to 0, so out_valid=0 and out_pc/out_addr/out_wdata=0.
REQ-026 SHALL give reset priority over simultaneous event and pop; an event presented in a reset cycle is lost, not counted, not flagged.
REQ-027 SHALL accept events from the first cycle after reset deasserts.

Configuration
REQ-028 SHALL, with WB_TRACE_DROP_CNT_EN defined, provide drop_cnt incremented by 1 per dropped event (REQ-021), saturating at 16'hFFFF.
REQ-029 SHALL, without WB_TRACE_DROP_CNT_EN, omit the drop_cnt port and counter entirely; all other behaviour identical, including overflow.

Verification
REQ-030 SHALL cover: reset, then event pc=0xBFC00000 addr=8 data=0x1234, out_ready=1 -> out_valid=1 next cycle with those fields, 0 the cycle after; count 0->1->0.
REQ-031 SHALL cover: events addr=0 wen=1 and addr=5 wen=0 -> out_valid stays 0, count stays 0, overflow=0.
REQ-032 SHALL cover: DEPTH=8, out_ready=0, 10 events data=1..10 -> count=8, overflow=1, drop_cnt=2 (macro on); draining yields data 1..8 in order.
REQ-033 SHALL cover: full buffer, event data=0x99 plus out_ready=1 same cycle -> count stays 8, no overflow, 0x99 emerges last.
REQ-034 SHALL cover: 20 events with out_ready toggling every cycle -> pointer wrap-around, order preserved, out_* stable while stalled.
REQ-035 SHALL cover: reset asserted with count=5 and an event pending -> next cycle count=0, out_valid=0, outputs 0, overflow=0.

Source files
------------

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: first-word-fall-through FIFO that captures CPU register-file
// writeback events ({pc, rd, wdata}) for an external trace checker.
// An event is a cycle with wb_rf_wen=1 and wb_rf_addr!=0. Events arriving
// while the buffer is full and not being popped are dropped. Each drop sets
// the sticky overflow flag.
// Optional feature: define WB_TRACE_DROP_CNT_EN to add the saturating 16-bit
// drop_cnt output port and its counter.
module wb_trace_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              wb_pc,
  input  logic                     wb_rf_wen,
  input  logic [4:0]               wb_rf_addr,
  input  logic [31:0]              wb_rf_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [4:0]               out_addr,
  output logic [31:0]              out_wdata,
  output logic [$clog2(DEPTH):0]   count,
`ifdef WB_TRACE_DROP_CNT_EN
  output logic                     overflow,
  output logic [15:0]              drop_cnt
`else
  output logic                     overflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  // Storage and state
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [4:0]    addr_mem_q  [DEPTH];
  logic [31:0]   wdata_mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          overflow_q, overflow_d;

  // Per-cycle decisions
  logic evt_s;
  logic pop_s;
  logic full_s;
  logic push_s;
  logic drop_s;

  // Classify the current cycle: event, pop, accepted push or dropped event.
  always_comb begin
    evt_s  = wb_rf_wen && (wb_rf_addr != 5'd0);
    full_s = (count_q == FULL_CNT);
    pop_s  = (count_q != {(AW+1){1'b0}}) && out_ready;
    // A pop on a full buffer frees the slot the new event lands in.
    push_s = evt_s && (!full_s || pop_s);
    drop_s = evt_s && full_s && !pop_s;
  end

  // Next-state values for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      2'b11:   count_d = count_q;
      2'b00:   count_d = count_q;
      default: count_d = count_q;
    endcase
    if (drop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control registers; reset wins over any concurrent event or pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {(AW+1){1'b0}};
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage: cleared on reset so an empty buffer presents zeros.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= 32'd0;
        addr_mem_q[i]  <= 5'd0;
        wdata_mem_q[i] <= 32'd0;
      end
    end else if (push_s) begin
      pc_mem_q[wr_ptr_q]    <= wb_pc;
      addr_mem_q[wr_ptr_q]  <= wb_rf_addr;
      wdata_mem_q[wr_ptr_q] <= wb_rf_wdata;
    end else begin
      pc_mem_q[wr_ptr_q]    <= pc_mem_q[wr_ptr_q];
      addr_mem_q[wr_ptr_q]  <= addr_mem_q[wr_ptr_q];
      wdata_mem_q[wr_ptr_q] <= wdata_mem_q[wr_ptr_q];
    end
  end

`ifdef WB_TRACE_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of dropped events.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= 16'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  // Head entry falls through straight from storage; it only moves on a pop.
  assign out_valid = (count_q != {(AW+1){1'b0}});
  assign out_pc    = pc_mem_q[rd_ptr_q];
  assign out_addr  = addr_mem_q[rd_ptr_q];
  assign out_wdata = wdata_mem_q[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Scoreboard bench for wb_trace_buffer. The driver applies inputs 2 time units
// after each rising edge and updates a queue-based reference model 1 unit after
// the edge. The monitor samples at the falling edge and compares against the
// model, popping the expected head whenever a pop is due.
module tb_wb_trace_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wb_pc;
  logic        wb_rf_wen;
  logic [4:0]  wb_rf_addr;
  logic [31:0] wb_rf_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_addr;
  logic [31:0] out_wdata;
  logic [3:0]  count;
  logic        overflow;
`ifdef WB_TRACE_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  wb_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .wb_pc      (wb_pc),
    .wb_rf_wen  (wb_rf_wen),
    .wb_rf_addr (wb_rf_addr),
    .wb_rf_wdata(wb_rf_wdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_addr   (out_addr),
    .out_wdata  (out_wdata),
    .count      (count),
`ifdef WB_TRACE_DROP_CNT_EN
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
`else
    .overflow   (overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  // Reference model: contents in arrival order plus flags.
  entry_t exp_q[$];
  bit     pop_seen = 1'b0;
  bit     ovf_m    = 1'b0;
  int     drop_m   = 0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, let the edge happen, update the model.
  task automatic step(input bit rst, input bit wen, input logic [4:0] addr,
                      input logic [31:0] pc, input logic [31:0] data, input bit rdy);
    int occ;
    entry_t e;
    reset = rst; wb_rf_wen = wen; wb_rf_addr = addr; wb_pc = pc;
    wb_rf_wdata = data; out_ready = rdy;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      ovf_m = 1'b0;
      drop_m = 0;
    end else begin
      occ = exp_q.size() + (pop_seen ? 1 : 0);
      if (wen && addr != 5'd0) begin
        if (occ < DEPTH || pop_seen) begin
          e.pc = pc; e.addr = addr; e.data = data;
          exp_q.push_back(e);
        end else begin
          ovf_m = 1'b1;
          if (drop_m < 65535) drop_m++;
        end
      end
    end
    pop_seen = 1'b0;
    #1;
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, rdy);
  endtask

  task automatic ev(input logic [31:0] data, input bit rdy);
    step(1'b0, 1'b1, 5'd3 + data[3:0], 32'h1000_0000 + data * 4, data, rdy);
  endtask

  task automatic zero_check(input string nm);
    chk({nm, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({nm, "_count"}, {28'd0, count}, 32'd0);
    chk({nm, "_ovf"},   {31'd0, overflow}, 32'd0);
    chk({nm, "_pc"},    out_pc, 32'd0);
    chk({nm, "_addr"},  {27'd0, out_addr}, 32'd0);
    chk({nm, "_data"},  out_wdata, 32'd0);
  endtask

  // Monitor: compare occupancy, flags and head entry; consume the head on a pop.
  initial begin : monitor
    entry_t h;
    bit stalled = 1'b0;
    logic [68:0] held = 69'd0;
    forever begin
      @(negedge clk);
      chk("count", {28'd0, count}, exp_q.size());
      chk("overflow", {31'd0, overflow}, {31'd0, ovf_m});
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
`ifdef WB_TRACE_DROP_CNT_EN
      chk("drop_cnt", {16'd0, drop_cnt}, drop_m);
`endif
      if (stalled && out_valid) begin
        chk("stable", {31'd0, {out_pc, out_addr, out_wdata} == held}, 32'd1);
      end
      stalled = out_valid && !out_ready && !reset;
      held = {out_pc, out_addr, out_wdata};
      if (exp_q.size() != 0) begin
        h = exp_q[0];
        chk("head_pc", out_pc, h.pc);
        chk("head_addr", {27'd0, out_addr}, {27'd0, h.addr});
        chk("head_data", out_wdata, h.data);
        if (out_ready && !reset) begin
          void'(exp_q.pop_front());
          pop_seen = 1'b1;
        end
      end
    end
  end

  // Driver: directed scenarios followed by randomized traffic.
  initial begin : driver
    reset = 1'b1; wb_rf_wen = 1'b0; wb_rf_addr = 5'd0; wb_pc = 32'd0;
    wb_rf_wdata = 32'd0; out_ready = 1'b0;
    @(posedge clk); #2;
    step(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    zero_check("rst");

    // Single event, one-cycle latency.
    step(1'b0, 1'b1, 5'd8, 32'hBFC0_0000, 32'h0000_1234, 1'b1);
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_pc", out_pc, 32'hBFC0_0000);
    chk("lat_data", out_wdata, 32'h0000_1234);
    idle(1'b1);
    chk("lat_empty", {31'd0, out_valid}, 32'd0);
    idle(1'b1);

    // Non-events.
    step(1'b0, 1'b1, 5'd0, 32'h1, 32'h2, 1'b1);
    step(1'b0, 1'b0, 5'd5, 32'h3, 32'h4, 1'b1);
    chk("nonevt_count", {28'd0, count}, 32'd0);
    chk("nonevt_valid", {31'd0, out_valid}, 32'd0);
    idle(1'b1);

    // Overfill by two, then drain in order.
    for (int i = 1; i <= 10; i++) ev(i, 1'b0);
    chk("full_count", {28'd0, count}, 32'd8);
    chk("full_ovf", {31'd0, overflow}, 32'd1);
`ifdef WB_TRACE_DROP_CNT_EN
    chk("full_drops", {16'd0, drop_cnt}, 32'd2);
`endif
    for (int i = 0; i < 9; i++) idle(1'b1);

    // Full plus simultaneous pop accepts the event.
    step(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 1; i <= 8; i++) ev(i, 1'b0);
    step(1'b0, 1'b1, 5'd9, 32'h0000_0099, 32'h0000_0099, 1'b1);
    chk("fullpop_count", {28'd0, count}, 32'd8);
    chk("fullpop_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 9; i++) idle(1'b1);

    // Wrap-around with toggling ready.
    for (int i = 0; i < 20; i++) ev(32'h100 + i, i[0]);
    for (int i = 0; i < 24; i++) idle(i[0]);

    // Reset with occupancy 5 and an event pending.
    for (int i = 0; i < 5; i++) ev(32'h200 + i, 1'b0);
    chk("pre_rst_count", {28'd0, count}, 32'd5);
    step(1'b1, 1'b1, 5'd7, 32'hDEAD_0000, 32'hBEEF, 1'b1);
    zero_check("rst5");

    // Randomized traffic with phases of different ready pressure.
    for (int seg = 0; seg < 20; seg++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(0, 100);
      for (int c = 0; c < 100; c++) begin
        bit r, w;
        r = ($urandom_range(0, 199) == 0);
        w = ($urandom_range(0, 3) != 0);
        step(r, w, 5'($urandom_range(0, 31)), $urandom, $urandom,
             ($urandom_range(0, 99) < rdy_pct));
      end
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
